// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one combinational ALU between two requesters.
// One operation in flight: IDLE accepts, EXEC drives the ALU, RESP holds the
// captured result until the consumer takes it.
module alu_arbiter #(
    parameter int WIDTH = 8,
    parameter int OPW   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [OPW-1:0]   req0_opcode,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [OPW-1:0]   req1_opcode,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] alu_dat_a,
    output logic [WIDTH-1:0] alu_dat_b,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             last_grant;
    logic             pend_id;
    logic             grant_vld;
    logic             winner;
    logic             accept;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // Arbitration: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        grant_vld = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            winner = ~last_grant;
        end else begin
            winner = req1_valid;
        end
    end

    // Next-state and handshake decode; readies only ever asserted in IDLE
    always_comb begin
        next_state = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    req0_ready = ~winner;
                    req1_ready = winner;
                    accept     = 1'b1;
                    next_state = EXEC;
                end
            end
            EXEC: next_state = RESP;
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operand capture on accept; these registers drive the ALU until the next accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            pend_id    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            op_q       <= winner ? req1_opcode : req0_opcode;
            a_q        <= winner ? req1_a : req0_a;
            b_q        <= winner ? req1_b : req0_b;
            pend_id    <= winner;
            last_grant <= winner;
        end
    end

    // Response register: load at the end of EXEC, release on consumer handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
        end else if (state == EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= pend_id;
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
        end else if (state == RESP && rsp_valid && rsp_ready) begin
            rsp_valid  <= 1'b0;
        end
    end

    assign alu_opcode = op_q;
    assign alu_dat_a  = a_q;
    assign alu_dat_b  = b_q;
    assign busy       = (state != IDLE);

endmodule
